ntt_butterfly: RTL and testbench

- Modular add/subtract butterfly for the NTT accelerator datapath, over the prime Q = 7681.
- Takes one coefficient from the coefficient buffer (a) and one from the normal datapath stream (b).
- Produces (a + b) mod Q and (a − b) mod Q, both registered.
- Twiddle multiplication is done upstream; this block only adds and subtracts.

---
 rtl/ntt_pkg.sv | 8 +
 rtl/mod_reduce.sv | 20 ++
 rtl/ntt_butterfly.sv | 55 +++++
 tb/tb_ntt_butterfly.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants and types for the NTT datapath
package ntt_pkg;
  localparam int NTT_Q = 7681;
  localparam int DATA_W = 32;
  localparam int COEFF_W = $clog2(NTT_Q);
  typedef logic [COEFF_W-1:0] coeff_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/mod_reduce.sv
// mod_reduce: combinational Barrett reduction of an unsigned word modulo Q
module mod_reduce import ntt_pkg::*; #(
  parameter int WIDTH = DATA_W,
  parameter int Q = NTT_Q
) (
  input  logic [WIDTH-1:0]       x,
  output logic [$clog2(Q)-1:0]   r
);
  localparam int CW = $clog2(Q);
  localparam int K = WIDTH + CW;
  localparam int PW = WIDTH + K + 1;
  localparam logic [PW-1:0] M = (PW'(1) << K) / PW'(Q);
  logic [WIDTH-1:0] q_est, rem;
  // quotient estimate is at most one short, so one conditional subtract finishes
  always_comb begin
    q_est = WIDTH'((PW'(x) * M) >> K);
    rem = x - q_est * WIDTH'(Q);
    r = CW'(rem >= WIDTH'(Q) ? rem - WIDTH'(Q) : rem);
  end
endmodule

// File: rtl/ntt_butterfly.sv
// ntt_butterfly: two-stage modular add/subtract butterfly
module ntt_butterfly import ntt_pkg::*; #(
  parameter int WIDTH = DATA_W,
  parameter int Q = NTT_Q
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] buffer_data_in,
  input  logic [WIDTH-1:0] normal_data_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] positive_data_out,
  output logic [WIDTH-1:0] negative_data_out
);
  localparam int CW = $clog2(Q);
  logic [CW-1:0] ra_c, rb_c, ra, rb, sum_m, diff_m;
  logic [CW:0] sum;
  logic signed [CW+1:0] diff;
  logic v1;
  mod_reduce #(.WIDTH(WIDTH), .Q(Q)) u_ra (.x(buffer_data_in), .r(ra_c));
  mod_reduce #(.WIDTH(WIDTH), .Q(Q)) u_rb (.x(normal_data_in), .r(rb_c));
  // stage 1: register canonical operands with their valid bit
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      ra <= '0;
      rb <= '0;
    end else begin
      v1 <= in_valid;
      ra <= ra_c;
      rb <= rb_c;
    end
  end
  // modular sum and difference of the canonical operands
  always_comb begin
    sum = {1'b0, ra} + {1'b0, rb};
    sum_m = sum >= (CW+1)'(Q) ? CW'(sum - (CW+1)'(Q)) : CW'(sum);
    diff = $signed({2'b00, ra}) - $signed({2'b00, rb});
    diff_m = diff < 0 ? CW'(diff + $signed((CW+2)'(Q))) : CW'(diff);
  end
  // stage 2: outputs update only on valid results and hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      positive_data_out <= '0;
      negative_data_out <= '0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        positive_data_out <= WIDTH'(sum_m);
        negative_data_out <= WIDTH'(diff_m);
      end
    end
  end
endmodule

// File: tb/tb_ntt_butterfly.sv
// tb_ntt_butterfly: scoreboard bench for the modular butterfly
module tb_ntt_butterfly;
  localparam logic [63:0] Q = 64'd7681;
  typedef struct {
    logic [31:0] p;
    logic [31:0] n;
    int due;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic out_valid;
  logic [31:0] pos, neg;
  exp_t q[$];
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  logic prev_rst = 1'b1;
  logic [31:0] hold_p = '0;
  logic [31:0] hold_n = '0;

  ntt_butterfly dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .buffer_data_in(a),
    .normal_data_in(b),
    .out_valid(out_valid),
    .positive_data_out(pos),
    .negative_data_out(neg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] rx, ry;
    exp_t e;
    rx = {32'd0, x} % Q;
    ry = {32'd0, y} % Q;
    e.p = 32'((rx + ry) % Q);
    e.n = 32'((rx + Q - ry) % Q);
    e.due = 0;
    return e;
  endfunction

  task automatic issue(input logic v, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] pe, input logic [31:0] ne);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    a = x;
    b = y;
    if (v) begin
      e.p = pe;
      e.n = ne;
      e.due = cyc + 2;
      q.push_back(e);
    end
  endtask

  task automatic issue_m(input logic v, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e = model(x, y);
    issue(v, x, y, e.p, e.n);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    a = 32'd123;
    b = 32'd456;
    if (q.size() > 0 && q[$].due == cyc + 1) void'(q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    logic due_now;
    exp_t e;
    if (prev_rst) begin
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_pos", pos, 32'd0);
      check("rst_neg", neg, 32'd0);
      hold_p = '0;
      hold_n = '0;
    end else begin
      due_now = q.size() > 0 && q[0].due == cyc;
      check("out_valid", 32'(out_valid), 32'(due_now));
      if (due_now) begin
        e = q.pop_front();
        check("positive", pos, e.p);
        check("negative", neg, e.n);
        check("pos_range", 32'(pos < 32'(Q)), 32'd1);
        check("neg_range", 32'(neg < 32'(Q)), 32'd1);
        hold_p = e.p;
        hold_n = e.n;
      end else begin
        check("hold_pos", pos, hold_p);
        check("hold_neg", neg, hold_n);
      end
    end
    prev_rst = rst;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1, 32'd1, 32'd3, 32'd4, 32'd7679);
    issue(1, 32'd2, 32'd4, 32'd6, 32'd7679);
    issue(0, 32'd0, 32'd0, 32'd0, 32'd0);
    issue(1, 32'd7679, 32'd6766, 32'd6764, 32'd913);
    issue(1, 32'd7681, 32'd0, 32'd0, 32'd0);
    issue(1, 32'hFFFF_FFFF, 32'd0, 32'd5568, 32'd5568);
    issue(1, 32'd5, 32'd5, 32'd10, 32'd0);
    issue(1, 32'd0, 32'd7680, 32'd7680, 32'd1);
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3455, 32'd0);
    repeat (3) issue(0, 32'd0, 32'd0, 32'd0, 32'd0);
    issue_m(1, 32'd100, 32'd7000);
    issue_m(1, 32'd200, 32'd300);
    reset_pulse();
    repeat (3) issue(0, 32'd0, 32'd0, 32'd0, 32'd0);
    issue_m(1, 32'd4000, 32'd5000);
    repeat (3) issue(0, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 10000; i++) issue_m($urandom_range(3) != 0, $urandom, $urandom);
    repeat (5) issue(0, 32'd0, 32'd0, 32'd0, 32'd0);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
